// File: rtl/hyperbus_rd_capture_if.sv
// Bus bundle for the HyperBus read-data capture stage.
// Groups the burst control, DDR capture inputs and the FWFT output stream
// so the controller/consumer side (master) and the capture block (slave)
// connect through one port.
//   start_i/len_i/abort_i/clear_i : burst control from the controller
//   datar_i/rwdsr_i               : DDR-captured DQ word and RWDS pair
//   dat_o/valid_o/ready_i         : FIFO head with consumer backpressure
//   busy_o/done_o/timeout_o       : burst status
//   overflow_o/phase_err_o        : sticky error flags
//   level_o                       : FIFO occupancy
interface hyperbus_rd_capture_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LEN_W = 9
) ();
  logic                     start_i;
  logic [LEN_W-1:0]         len_i;
  logic                     abort_i;
  logic                     clear_i;
  logic [2*WIDTH-1:0]       datar_i;
  logic [1:0]               rwdsr_i;
  logic [2*WIDTH-1:0]       dat_o;
  logic                     valid_o;
  logic                     ready_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     timeout_o;
  logic                     overflow_o;
  logic                     phase_err_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport master (
    output start_i, len_i, abort_i, clear_i, datar_i, rwdsr_i, ready_i,
    input  dat_o, valid_o, busy_o, done_o, timeout_o, overflow_o,
           phase_err_o, level_o
  );

  modport slave (
    input  start_i, len_i, abort_i, clear_i, datar_i, rwdsr_i, ready_i,
    output dat_o, valid_o, busy_o, done_o, timeout_o, overflow_o,
           phase_err_o, level_o
  );
endinterface

// File: rtl/hyperbus_rd_capture.sv
// HyperBus read-data capture stage.
// Detects RWDS read strobes (pair 2'b10) while a burst is active, counts
// them against the requested length and buffers the captured words in a
// first-word-fall-through FIFO. A burst ends on the last strobe (done_o),
// after TIMEOUT strobe-less cycles (timeout_o) or on abort_i (FIFO flushed).
// Ports:
//   clk90 : capture clock
//   rst   : asynchronous, active-high reset
//   bus   : hyperbus_rd_capture_if slave modport (control, DDR data, FIFO
//           output stream, status and sticky error flags)
module hyperbus_rd_capture #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 9,
  parameter int TIMEOUT = 64
) (
  input logic                   clk90,
  input logic                   rst,
  hyperbus_rd_capture_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [LEN_W-1:0]   remaining_r, remaining_s;
  logic [TW-1:0]      timer_r, timer_s;
  logic               done_r, done_s;
  logic               timeout_r, timeout_s;
  logic               overflow_r, phase_err_r;
  logic               strobe_s, phase_set_s;
  logic               pop_s, push_s, drop_s, full_s, empty_s;
  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]      count_r;

  // Burst FSM: next state, remaining/timer updates and end-of-burst pulses.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    timer_s     = timer_r;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    strobe_s    = 1'b0;
    phase_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != {LEN_W{1'b0}}) begin
            state_s     = ST_CAPTURE;
            remaining_s = bus.len_i;
            timer_s     = TMR_LOAD;
          end else begin
            // Zero-length burst completes immediately.
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        phase_set_s = (bus.rwdsr_i == 2'b01);
        if (bus.abort_i) begin
          // Abort outranks a strobe in the same cycle; the word is discarded.
          state_s     = ST_IDLE;
          remaining_s = {LEN_W{1'b0}};
          timer_s     = {TW{1'b0}};
        end else if (bus.rwdsr_i == 2'b10) begin
          strobe_s    = 1'b1;
          remaining_s = remaining_r - LEN_W'(1);
          timer_s     = TMR_LOAD;
          if (remaining_r == LEN_W'(1)) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else if (timer_r == TW'(1)) begin
          timeout_s = 1'b1;
          timer_s   = {TW{1'b0}};
          state_s   = ST_IDLE;
        end else begin
          timer_s = timer_r - TW'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        remaining_s = {LEN_W{1'b0}};
        timer_s     = {TW{1'b0}};
      end
    endcase
  end

  // FSM state, counters and the registered done/timeout pulses.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= {LEN_W{1'b0}};
      timer_r     <= {TW{1'b0}};
      done_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      timer_r     <= timer_s;
      done_r      <= done_s;
      timeout_r   <= timeout_s;
    end
  end

  // FIFO handshakes. A full FIFO still accepts a word when the head is
  // popped in the same cycle, so only a full-and-not-popping strobe drops.
  always_comb begin
    empty_s = (count_r == {LW{1'b0}});
    full_s  = (count_r == LVL_FULL);
    pop_s   = !empty_s && bus.ready_i;
    push_s  = strobe_s && (!full_s || pop_s);
    drop_s  = strobe_s && full_s && !pop_s;
  end

  // FIFO pointers and occupancy; abort flushes regardless of state.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else if (bus.abort_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only observable through a non-empty head,
  // so the array needs no reset.
  always_ff @(posedge clk90) begin
    if (push_s && !bus.abort_i) begin
      mem_r[wr_ptr_r] <= bus.datar_i;
    end
  end

  // Sticky error flags: a set in the same cycle as clear_i wins.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      phase_err_r <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clear_i) begin
        overflow_r <= 1'b0;
      end
      if (phase_set_s) begin
        phase_err_r <= 1'b1;
      end else if (bus.clear_i) begin
        phase_err_r <= 1'b0;
      end
    end
  end

  // Head word is forced to zero while empty so dat_o is clean after reset/flush.
  assign bus.dat_o       = empty_s ? {(2*WIDTH){1'b0}} : mem_r[rd_ptr_r];
  assign bus.valid_o     = !empty_s;
  assign bus.level_o     = count_r;
  assign bus.busy_o      = (state_r == ST_CAPTURE);
  assign bus.done_o      = done_r;
  assign bus.timeout_o   = timeout_r;
  assign bus.overflow_o  = overflow_r;
  assign bus.phase_err_o = phase_err_r;

endmodule

// File: tb/tb_hyperbus_rd_capture.sv
// Self-checking bench for hyperbus_rd_capture (WIDTH=8, DEPTH=16, LEN_W=9,
// TIMEOUT=64). A behavioural model (word queue, remaining count, silent
// cycle count) predicts every output after each clk90 edge.
module tb_hyperbus_rd_capture;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int LEN_W   = 9;
  localparam int TIMEOUT = 64;

  logic clk90 = 1'b0;
  logic rst   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  hyperbus_rd_capture_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

  hyperbus_rd_capture #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk90 (clk90),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 clk90 = ~clk90;

  // Reference model state
  logic [15:0] mq[$];
  bit m_busy, m_done, m_to, m_ovf, m_perr;
  int m_rem, m_silent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_done = 0; m_to = 0; m_ovf = 0; m_perr = 0;
    m_rem = 0; m_silent = 0;
  endtask

  // Apply one clock edge worth of behaviour using the inputs seen at the edge.
  task automatic model_edge();
    bit pop, strobe, set_ovf, set_perr;
    pop      = (mq.size() != 0) && bus.ready_i;
    strobe   = m_busy && !bus.abort_i && (bus.rwdsr_i == 2'b10);
    set_ovf  = strobe && (mq.size() == DEPTH) && !pop;
    set_perr = m_busy && (bus.rwdsr_i == 2'b01);
    m_done = 0;
    m_to   = 0;
    if (bus.abort_i) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (strobe && !set_ovf) mq.push_back(bus.datar_i);
    end
    if (!m_busy) begin
      if (bus.start_i) begin
        if (bus.len_i == 0) m_done = 1;
        else begin
          m_busy = 1; m_rem = bus.len_i; m_silent = 0;
        end
      end
    end else if (bus.abort_i) begin
      m_busy = 0;
    end else if (strobe) begin
      m_rem--;
      m_silent = 0;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
      end
    end else begin
      m_silent++;
      if (m_silent == TIMEOUT) begin
        m_busy = 0; m_to = 1;
      end
    end
    if (set_ovf) m_ovf = 1; else if (bus.clear_i) m_ovf = 0;
    if (set_perr) m_perr = 1; else if (bus.clear_i) m_perr = 0;
  endtask

  task automatic check_all();
    chk("valid", 32'(bus.valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("dat", 32'(bus.dat_o), 32'(mq[0]));
    else chk("dat_empty", 32'(bus.dat_o), 32'd0);
    chk("level", 32'(bus.level_o), 32'(mq.size()));
    chk("busy", 32'(bus.busy_o), 32'(m_busy));
    chk("done", 32'(bus.done_o), 32'(m_done));
    chk("timeout", 32'(bus.timeout_o), 32'(m_to));
    chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
    chk("phase_err", 32'(bus.phase_err_o), 32'(m_perr));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
    chk({tag, "_dat"}, 32'(bus.dat_o), 32'd0);
    chk({tag, "_level"}, 32'(bus.level_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_timeout"}, 32'(bus.timeout_o), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow_o), 32'd0);
    chk({tag, "_phase_err"}, 32'(bus.phase_err_o), 32'd0);
  endtask

  // One clock: inputs are held across the edge, outputs checked 1 time unit later.
  task automatic cyc();
    @(posedge clk90);
    if (rst) model_reset(); else model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.rwdsr_i = 2'b00;
      bus.datar_i = 16'($urandom);
      cyc();
    end
  endtask

  task automatic start(input int len);
    bus.start_i = 1'b1;
    bus.len_i   = LEN_W'(len);
    cyc();
    bus.start_i = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] d);
    bus.rwdsr_i = 2'b10;
    bus.datar_i = d;
    cyc();
    bus.rwdsr_i = 2'b00;
  endtask

  initial begin
    bus.start_i = 1'b0; bus.len_i = '0; bus.abort_i = 1'b0; bus.clear_i = 1'b0;
    bus.datar_i = '0; bus.rwdsr_i = 2'b00; bus.ready_i = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk90);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    // Basic burst of 4, consumer always ready
    start(4);
    strobe(16'h1111); strobe(16'h2222); strobe(16'h3333); strobe(16'h4444);
    idle(3);
    chk("t1_level_zero", 32'(bus.level_o), 32'd0);

    // Burst of 8 with gaps, including a 3-cycle gap; no timeout expected
    start(8);
    for (int i = 0; i < 8; i++) begin
      strobe(16'($urandom));
      idle((i == 3) ? 3 : 1);
    end
    idle(2);

    // Strobes stop after word 3: timeout, words retained
    bus.ready_i = 1'b0;
    start(8);
    for (int i = 0; i < 3; i++) strobe(16'($urandom));
    idle(TIMEOUT + 6);
    chk("t2_timeout_level", 32'(bus.level_o), 32'd3);
    bus.ready_i = 1'b1;
    idle(5);

    // Overflow: 20 words into a 16-deep FIFO with no consumer
    bus.ready_i = 1'b0;
    start(20);
    for (int i = 0; i < 20; i++) strobe(16'($urandom));
    chk("t3_level_full", 32'(bus.level_o), 32'd16);
    chk("t3_overflow", 32'(bus.overflow_o), 32'd1);
    bus.ready_i = 1'b1;
    idle(18);
    bus.clear_i = 1'b1;
    cyc();
    bus.clear_i = 1'b0;
    chk("t3_overflow_cleared", 32'(bus.overflow_o), 32'd0);

    // Full FIFO with strobe and pop in the same cycle
    bus.ready_i = 1'b0;
    start(20);
    for (int i = 0; i < 16; i++) strobe(16'($urandom));
    bus.ready_i = 1'b1;
    strobe(16'hBEEF);
    chk("t4_level_held", 32'(bus.level_o), 32'd16);
    chk("t4_no_overflow", 32'(bus.overflow_o), 32'd0);
    bus.ready_i = 1'b0;
    bus.abort_i = 1'b1; bus.rwdsr_i = 2'b10;
    cyc();
    bus.abort_i = 1'b0; bus.rwdsr_i = 2'b00;
    bus.ready_i = 1'b1;
    idle(2);

    // Abort after 5 strobes with a strobe in the abort cycle
    bus.ready_i = 1'b0;
    start(10);
    for (int i = 0; i < 5; i++) strobe(16'($urandom));
    bus.abort_i = 1'b1; bus.rwdsr_i = 2'b10; bus.datar_i = 16'hDEAD;
    cyc();
    bus.abort_i = 1'b0; bus.rwdsr_i = 2'b00;
    chk("t5_abort_level", 32'(bus.level_o), 32'd0);
    chk("t5_abort_valid", 32'(bus.valid_o), 32'd0);
    chk("t5_abort_busy", 32'(bus.busy_o), 32'd0);
    idle(2);
    bus.ready_i = 1'b1;

    // Phase error, clear colliding with a new set, then a plain clear
    start(6);
    strobe(16'($urandom));
    bus.rwdsr_i = 2'b01;
    cyc();
    chk("t5_phase_err", 32'(bus.phase_err_o), 32'd1);
    bus.clear_i = 1'b1;
    cyc();
    chk("t5_phase_set_wins", 32'(bus.phase_err_o), 32'd1);
    bus.rwdsr_i = 2'b00;
    cyc();
    bus.clear_i = 1'b0;
    chk("t5_phase_cleared", 32'(bus.phase_err_o), 32'd0);
    for (int i = 0; i < 5; i++) strobe(16'($urandom));
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bus.start_i = ($urandom_range(0, 15) == 0);
      bus.len_i   = LEN_W'($urandom_range(0, 24));
      bus.rwdsr_i = 2'($urandom);
      bus.datar_i = 16'($urandom);
      bus.ready_i = ($urandom_range(0, 3) != 0);
      bus.abort_i = ($urandom_range(0, 63) == 0);
      bus.clear_i = ($urandom_range(0, 31) == 0);
      cyc();
    end
    bus.start_i = 1'b0; bus.clear_i = 1'b0; bus.rwdsr_i = 2'b00;
    bus.abort_i = 1'b1;
    cyc();
    bus.abort_i = 1'b0;
    bus.clear_i = 1'b1;
    cyc();
    bus.clear_i = 1'b0;

    // Asynchronous reset mid-burst with 7 words buffered
    bus.ready_i = 1'b0;
    start(12);
    for (int i = 0; i < 7; i++) strobe(16'($urandom));
    chk("t6_level_seven", 32'(bus.level_o), 32'd7);
    bus.rwdsr_i = 2'b01;
    cyc();
    bus.rwdsr_i = 2'b00;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    cyc();
    rst = 1'b0;
    bus.ready_i = 1'b1;
    idle(2);

    // Zero-length start in IDLE: single done pulse
    start(0);
    chk("t7_done_pulse", 32'(bus.done_o), 32'd1);
    idle(1);
    chk("t7_done_single", 32'(bus.done_o), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hyperbus_rd_capture.md
Name: hyperbus_rd_capture

Overview:
Parametrised read-data capture stage for the HyperBus controller family. It takes the double-width DQ words and RWDS sample pairs produced by the DDR input cells, detects valid read strobes, and counts burst words against a requested length. Captured words are buffered in a first-word-fall-through FIFO with consumer backpressure. It adds strobe timeout, overflow and phase-error detection, and abort/flush handling, none of which the single-register read path provides.

Parameters:
WIDTH, 8, HyperBus DQ width; captured word is 2*WIDTH bits
DEPTH, 16, FIFO depth in words; power of two, >= 2
LEN_W, 9, width of burst length input/counter (max burst 2^LEN_W-1 words)
TIMEOUT, 64, clk90 cycles without a strobe before the burst is abandoned; >= 2

Ports:
clk90  in  1  capture clock
rst  in  1  asynchronous, active-high reset
start_i  in  1  single-cycle pulse: begin capturing a burst
len_i  in  LEN_W  expected words in burst, sampled on start_i
abort_i  in  1  terminate burst and flush FIFO
clear_i  in  1  clear sticky error flags
datar_i  in  2*WIDTH  DDR-captured DQ word
rwdsr_i  in  2  DDR-captured RWDS pair
dat_o  out  2*WIDTH  FIFO head word
valid_o  out  1  dat_o holds a word
ready_i  in  1  consumer accepts dat_o (pop when valid_o && ready_i)
busy_o  out  1  high in CAPTURE state
done_o  out  1  one-cycle pulse: all len_i words strobed
timeout_o  out  1  one-cycle pulse: burst abandoned on timeout
overflow_o  out  1  sticky: strobed word dropped, FIFO full
phase_err_o  out  1  sticky: rwdsr_i==2'b01 seen during CAPTURE
level_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst high): state IDLE, FIFO empty, valid_o=0, dat_o=0, busy_o=0, done_o=0, timeout_o=0, overflow_o=0, phase_err_o=0, level_o=0, counters 0.
- Strobe: cycle in CAPTURE with rwdsr_i==2'b10. rwdsr_i 2'b00 or 2'b11 is ignored. rwdsr_i 2'b01 sets phase_err_o and is not a strobe.
- IDLE:
  - start_i with len_i!=0: remaining<=len_i, timer<=TIMEOUT, go to CAPTURE.
  - start_i with len_i==0: done_o pulses the next cycle; stay in IDLE.
  - Strobes are ignored in IDLE.
- CAPTURE, priority order:
  - abort_i: go to IDLE next cycle, FIFO flushed (level_o=0, valid_o=0 next cycle), no done_o. Any strobe in the same cycle is discarded.
  - strobe:
    - Push datar_i if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise drop the word and set overflow_o.
    - Decrement remaining whether or not the word was stored. Reload timer to TIMEOUT.
    - If remaining==1, pulse done_o the next cycle and go to IDLE.
  - no strobe: decrement timer. At timer==1, pulse timeout_o the next cycle and go to IDLE. The FIFO keeps its words.
- start_i in CAPTURE is ignored.
- FIFO:
  - First-word-fall-through. A push into an empty FIFO gives valid_o=1 and dat_o=word in the cycle after the strobe (latency 1).
  - Pop and push in the same cycle are both honoured; level_o is unchanged.
  - Pop when empty has no effect.
  - Pointers wrap modulo DEPTH. level_o ranges 0..DEPTH.
- clear_i clears overflow_o and phase_err_o. If a set condition occurs in the same cycle as clear_i, the set wins.
- done_o and timeout_o are mutually exclusive. busy_o deasserts in the same cycle either pulse is high.

Test Plan:
- WIDTH=8, DEPTH=16: start_i with len_i=4, strobes with datar_i=16'h1111..16'h4444 on consecutive cycles, ready_i=1 -> valid_o from the cycle after the first strobe, words out in order, done_o pulse 1 cycle after the 4th strobe, level_o returns to 0.
- len_i=8, rwdsr_i alternating 2'b10/2'b00 with a 3-cycle 2'b00 gap mid-burst, TIMEOUT=64 -> 8 words captured, no timeout_o; repeat with no strobes after word 3 -> timeout_o exactly 64 cycles after the last strobe, level_o=3.
- ready_i=0, len_i=20, DEPTH=16 -> level_o saturates at 16, overflow_o=1, done_o after the 20th strobe; first 16 words pop in order; clear_i -> overflow_o=0.
- FIFO full, strobe and pop in the same cycle -> word accepted, overflow_o stays 0, level_o stays 16.
- abort_i after 5 strobes with a strobe in the same cycle -> state IDLE, level_o=0, valid_o=0, no done_o; rwdsr_i=2'b01 in CAPTURE -> phase_err_o=1.
- rst asserted mid-burst with level_o=7 -> all outputs at reset values immediately; start_i with len_i=0 in IDLE -> done_o single pulse.
